// File: rtl/ogpu_quad_rom_streamer.sv
// Read sequencer for the quad test ROM: walks a word range, hides the one-cycle ROM latency
// behind a credit-managed skid FIFO and emits a valid/ready stream with sop/eop markers.
// Optional OGPU_QUAD_STREAM_CSUM_EN adds a running wrap-around checksum of transferred words.
module ogpu_quad_rom_streamer #(
    parameter int ADDR_W         = 13,
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 8192,
    parameter int WORDS_PER_QUAD = 8,
    parameter int COUNT_W        = 11,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] quad_count,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [1:0]         status,
    output logic [ADDR_W-1:0]  rom_address,
    output logic               rom_chipselect,
    output logic               rom_clken,
    input  logic [DATA_W-1:0]  rom_readdata,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop
`ifdef OGPU_QUAD_STREAM_CSUM_EN
    ,
    output logic [DATA_W-1:0]  csum
`endif
);
    localparam int END_W = ADDR_W + COUNT_W + 3;
    localparam int WIQ_W = $clog2(WORDS_PER_QUAD);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = DATA_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [END_W-1:0]  words_left_q, words_left_d;
    logic [WIQ_W-1:0]  wiq_q, wiq_d;
    logic              inflight_q, inflight_d;
    logic              tag_sop_q, tag_sop_d;
    logic              tag_eop_q, tag_eop_d;
    logic [1:0]        status_q, status_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];

    logic             issue, flush, push, pop;
    logic [END_W-1:0] end_w;

    // Credit rule: registered occupancy plus the read still in flight must leave a free slot.
    assign issue = (state_q == S_RUN) && !abort &&
                   ((CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q) < (CNT_W+1)'(FIFO_DEPTH));
    assign flush = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign push  = inflight_q && !flush;
    assign pop   = out_valid && out_ready;
    assign end_w = END_W'(base_addr) + END_W'(quad_count) * END_W'(WORDS_PER_QUAD);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {tag_sop_q, tag_eop_q, rom_readdata};
                wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        wiq_d        = wiq_q;
        status_d     = status_q;
        inflight_d   = issue;
        tag_sop_d    = tag_sop_q;
        tag_eop_d    = tag_eop_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d       = base_addr;
                    words_left_d = END_W'(quad_count) * END_W'(WORDS_PER_QUAD);
                    wiq_d        = '0;
                    if (quad_count == '0) begin
                        state_d  = S_DONE;
                        status_d = 2'b00;
                    end else if (end_w > END_W'(DEPTH)) begin
                        state_d  = S_DONE;
                        status_d = 2'b01;
                    end else begin
                        state_d  = S_RUN;
                        status_d = 2'b00;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = 2'b10;
                end else if (issue) begin
                    addr_d       = addr_q + ADDR_W'(1);
                    words_left_d = words_left_q - END_W'(1);
                    wiq_d        = (wiq_q == WIQ_W'(WORDS_PER_QUAD - 1)) ? '0 : wiq_q + WIQ_W'(1);
                    tag_sop_d    = (wiq_q == '0);
                    tag_eop_d    = (wiq_q == WIQ_W'(WORDS_PER_QUAD - 1));
                    if (words_left_q == END_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d  = S_DONE;
                    status_d = 2'b10;
                end else if (!inflight_q && (count_d == '0)) begin
                    // Leaving on the final pop edge puts done right after the last beat.
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            wiq_q        <= '0;
            status_q     <= 2'b00;
            inflight_q   <= 1'b0;
            tag_sop_q    <= 1'b0;
            tag_eop_q    <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            wiq_q        <= wiq_d;
            status_q     <= status_d;
            inflight_q   <= inflight_d;
            tag_sop_q    <= tag_sop_d;
            tag_eop_q    <= tag_eop_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign status         = status_q;
    assign rom_address    = addr_q;
    assign rom_chipselect = issue;
    assign rom_clken      = issue;
    assign out_valid      = (count_q != '0);
    assign out_data       = mem_q[rd_ptr_q][DATA_W-1:0];
    assign out_sop        = out_valid && mem_q[rd_ptr_q][DATA_W+1];
    assign out_eop        = out_valid && mem_q[rd_ptr_q][DATA_W];

`ifdef OGPU_QUAD_STREAM_CSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == S_IDLE) && start) csum_d = '0;
        else if (pop)                     csum_d = csum_q + out_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= '0;
        else          csum_q <= csum_d;
    end

    assign csum = csum_q;
`else
    // Checksum disabled: no port and no adder.
`endif
endmodule

// File: tb/tb_ogpu_quad_rom_streamer.sv
// Directed bench for ogpu_quad_rom_streamer: ROM model, expected-beat queue filled at command
// issue and drained on stream handshakes; covers range, zero-count, stall, abort and reset paths.
module tb_ogpu_quad_rom_streamer;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [12:0] base_addr;
    logic [10:0] quad_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [12:0] rom_address;
    logic        rom_chipselect;
    logic        rom_clken;
    logic [31:0] rom_q;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
`ifdef OGPU_QUAD_STREAM_CSUM_EN
    logic [31:0] csum;
`endif

    ogpu_quad_rom_streamer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .quad_count     (quad_count),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .status         (status),
        .rom_address    (rom_address),
        .rom_chipselect (rom_chipselect),
        .rom_clken      (rom_clken),
        .rom_readdata   (rom_q),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_sop        (out_sop),
        .out_eop        (out_eop)
`ifdef OGPU_QUAD_STREAM_CSUM_EN
        ,
        .csum           (csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [12:0] a);
        return {3'b010, a, 3'b101, ~a};
    endfunction

    always @(posedge clk) begin
        if (rom_clken) rom_q <= rom_word(rom_address);
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [33:0] sb[$];
    logic [12:0] exp_addr;
    logic [31:0] csum_model;
    logic [31:0] done_csum;
    int          beats = 0, cs_cnt = 0, done_cnt = 0;
    int          cmd_b0, first_cyc, last_cyc, done_cyc, last_valid_cyc;
    logic [3:0]  rpat = 4'b1001;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        if (reset_n) begin
            if (rom_chipselect) begin
                cs_cnt++;
                check("rom_addr", 64'(rom_address), 64'(exp_addr));
                check("rom_clken", 64'(rom_clken), 64'(1));
                exp_addr = exp_addr + 13'd1;
            end
            if (out_valid) begin
                last_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(out_valid), 64'(0));
                end else begin
                    check("beat", 64'({out_sop, out_eop, out_data}), 64'(sb[0]));
                    if (out_ready) begin
                        if (beats == cmd_b0) first_cyc = cyc;
                        last_cyc   = cyc;
                        csum_model = csum_model + sb[0][31:0];
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef OGPU_QUAD_STREAM_CSUM_EN
                done_csum = csum;
`else
                done_csum = csum_model;
`endif
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic prime(input logic [12:0] base, input int n);
        for (int i = 0; i < n; i++)
            sb.push_back({(i % 8 == 0), (i % 8 == 7), rom_word(13'(int'(base) + i))});
        exp_addr   = base;
        csum_model = '0;
        cmd_b0     = beats;
    endtask

    task automatic do_cmd(input logic [12:0] base, input logic [10:0] qc, input bit tog,
                          input bit poke, input logic [1:0] exp_status);
        int n, d0, c0, acc;
        n  = (exp_status == 2'b00) ? int'(qc) * 8 : 0;
        prime(base, n);
        d0 = done_cnt;
        c0 = cs_cnt;
        base_addr  = base;
        quad_count = qc;
        start      = 1'b1;
        step();
        start = 1'b0;
        acc   = cyc;
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
            if (tog) out_ready = rpat[i % 4];
            if (poke) start = (i == 4);
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("done_seen", 64'(done_cnt - d0), 64'(1));
        check("status", 64'(status), 64'(exp_status));
        check("beat_count", 64'(beats - cmd_b0), 64'(n));
        check("read_count", 64'(cs_cnt - c0), 64'(n));
        check("queue_empty", 64'(sb.size()), 64'(0));
        if (n == 0) begin
            check("done_latency", 64'(done_cyc - acc), 64'(0));
        end else begin
            check("done_after_last", 64'(done_cyc - last_cyc), 64'(1));
            if (!tog) begin
                check("first_latency", 64'(first_cyc - acc), 64'(2));
                check("no_bubbles", 64'(last_cyc - first_cyc), 64'(n - 1));
            end
        end
`ifdef OGPU_QUAD_STREAM_CSUM_EN
        check("csum", 64'(done_csum), 64'(csum_model));
`endif
        step();
        step();
        check("single_done", 64'(done_cnt - d0), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));
        sb.delete();
    endtask

    initial begin
        int d0, ab_cyc;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        quad_count = '0;
        out_ready  = 1'b1;
        exp_addr   = '0;
        csum_model = '0;
        done_csum  = '0;
        cmd_b0 = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0; last_valid_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_status", 64'(status), 64'(0));
        check("rst_cs", 64'({rom_chipselect, rom_clken}), 64'(0));
        check("rst_addr", 64'(rom_address), 64'(0));
        check("rst_stream", 64'({out_valid, out_sop, out_eop}), 64'(0));
        reset_n = 1'b1;

        do_cmd(13'd0, 11'd2, 1'b0, 1'b0, 2'b00);
        do_cmd(13'd0, 11'd2, 1'b1, 1'b0, 2'b00);
        do_cmd(13'd8184, 11'd1, 1'b0, 1'b0, 2'b00);
        do_cmd(13'd8185, 11'd1, 1'b0, 1'b0, 2'b01);
        do_cmd(13'd0, 11'd1500, 1'b0, 1'b0, 2'b01);
        do_cmd(13'd64, 11'd0, 1'b0, 1'b0, 2'b00);
        do_cmd(13'd500, 11'd2, 1'b1, 1'b1, 2'b00);

        // Abort after five transferred beats, holding ready low in the abort cycle.
        prime(13'd200, 16);
        d0         = done_cnt;
        base_addr  = 13'd200;
        quad_count = 11'd2;
        start      = 1'b1;
        step();
        start  = 1'b0;
        ab_cyc = -10;
        for (int i = 0; i < 200 && done_cnt == d0; i++) begin
            if (ab_cyc < 0 && beats - cmd_b0 == 5) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                ab_cyc    = cyc;
            end else begin
                abort     = 1'b0;
                out_ready = 1'b1;
            end
            step();
        end
        abort     = 1'b0;
        out_ready = 1'b1;
        check("abort_done", 64'(done_cnt - d0), 64'(1));
        check("abort_status", 64'(status), 64'(2));
        check("abort_beats", 64'(beats - cmd_b0), 64'(5));
        check("abort_done_cycle", 64'(done_cyc - ab_cyc), 64'(1));
        check("abort_valid_drop", 64'(last_valid_cyc - ab_cyc), 64'(0));
`ifdef OGPU_QUAD_STREAM_CSUM_EN
        check("abort_csum", 64'(done_csum), 64'(csum_model));
`endif
        sb.delete();
        step();
        step();
        check("abort_idle", 64'({busy, done}), 64'(0));

        // Reset in the middle of a run, then a clean run with no replayed data.
        prime(13'd300, 16);
        base_addr  = 13'd300;
        quad_count = 11'd2;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'({busy, done}), 64'(0));
        check("midrst_status", 64'(status), 64'(0));
        check("midrst_rom", 64'({rom_chipselect, rom_clken, rom_address}), 64'(0));
        check("midrst_stream", 64'({out_valid, out_sop, out_eop}), 64'(0));
        sb.delete();
        step();
        step();
        reset_n = 1'b1;
        do_cmd(13'd40, 11'd1, 1'b0, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ogpu_quad_rom_streamer.md
# ogpu_quad_rom_streamer

Read sequencer for the 32-bit x 8192-word quad data test ROM. On a start command it walks a contiguous range of ROM words, one quad at a time, and issues one read per word. It absorbs the ROM's one-cycle read latency and drives the words onto a valid/ready beat stream with start-of-quad and end-of-quad markers. It sits between the HPS-facing control registers and the OpenGPU quad input path.

## Interface
- ADDR_W, 13, ROM word-address width
- DATA_W, 32, ROM/stream data width
- DEPTH, 8192, ROM words; legal addresses 0..DEPTH-1
- WORDS_PER_QUAD, 8, words per quad (4 vertices x X/Y); must be ≥2
- COUNT_W, 11, width of quad count
- FIFO_DEPTH, 4, output skid FIFO entries
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe, sampled only in IDLE
- base_addr  in  ADDR_W  first word address, captured on accepted start
- quad_count  in  COUNT_W  quads to stream, captured on accepted start
- abort  in  1  stop current run
- busy  out  1  high in RUN/DRAIN
- done  out  1  one-cycle pulse at end of every accepted command
- status  out  2  00 ok, 01 range error, 10 aborted; held until next accepted start
- rom_address  out  ADDR_W  ROM word address
- rom_chipselect  out  1  high on read-issue cycles
- rom_clken  out  1  equals rom_chipselect
- rom_readdata  in  DATA_W  ROM q, valid the cycle after issue
- out_data  out  DATA_W  stream word
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_sop  out  1  first word of a quad
- out_eop  out  1  last word of a quad

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE + start=1 → capture inputs and compute end = base_addr + quad_count*WORDS_PER_QUAD at ADDR_W+COUNT_W+3 bits without truncation.
  - quad_count=0 → DONE, status=00, no reads.
  - end > DEPTH → DONE, status=01, no reads.
  - Otherwise → RUN.
- RUN: issue a read when occupancy + inflight < FIFO_DEPTH. Occupancy is the FIFO entry count registered at the start of the cycle. Inflight is a 1-bit count of reads issued last cycle.
  - Each issue increments the address and a word-in-quad counter (0..WORDS_PER_QUAD-1).
  - sop and eop tags travel with each read.
  - After the last issue → DRAIN.
- DRAIN: no issues. When inflight=0 and the FIFO is empty → DONE.
- DONE: done=1 for one cycle, then IDLE.
- Capture: rom_readdata is written into the FIFO in the cycle after issue, unconditionally. Space is guaranteed by the credit rule.
- Output: the FIFO head drives out_data, out_sop and out_eop. A beat transfers when out_valid & out_ready. Push and pop in the same cycle are allowed.
- abort in RUN or DRAIN: stop issuing immediately, discard the inflight read, and flush the FIFO next edge. out_valid=0 from the cycle after abort. Then DONE with status=10. abort in IDLE or DONE is ignored.
- start outside IDLE is ignored; it is not queued.
- abort and start in the same IDLE cycle: start wins.

## Timing
- Reset values: busy=0, done=0, status=00, rom_chipselect=0, rom_clken=0, rom_address=0, out_valid=0, out_sop=0, out_eop=0, FIFO empty, state IDLE.
- Start accepted at edge E0: first issue is in cycle E0→E1, data is captured at E2, out_valid=1 after E2. First-beat latency is 2 cycles.
- With out_ready held high, throughput is 1 word/cycle with no bubbles.
- The final beat's transfer edge is followed by done=1 for exactly one cycle, then busy=0 in the same cycle as done.
- The range-error or zero-count path produces done 1 cycle after start is sampled.
- While out_valid=1 and out_ready=0, out_data, out_sop and out_eop are held stable.
- Reset asserted mid-run returns all state and outputs to reset values immediately. The discarded data is not replayed.

## Configuration
- OGPU_QUAD_STREAM_CSUM_EN defined: adds output csum[DATA_W-1:0].
  - Holds the 32-bit wrap-around sum of all words transferred on the stream in the current command.
  - Cleared on accepted start; final value is valid when done=1.
  - Not updated by flushed words.
- Undefined: no csum port and no adder logic.

## Test plan
- Reset: hold reset_n=0, then release → every output equals its reset value; start is accepted on the first cycle after release.
- base_addr=0, quad_count=2, out_ready=1 → 16 beats on consecutive cycles, addresses 0..15 in order, sop on beats 0 and 8, eop on beats 7 and 15, done 1 cycle after beat 15, status=00.
- Same run with out_ready toggling 1,0,0,1 repeating → same 16 words in order, no loss or duplication, data stable while stalled, FIFO never overflows.
- base_addr=8184, quad_count=1 → words 8184..8191 streamed, status=00. base_addr=8185, quad_count=1 → status=01, no rom_chipselect, done 1 cycle after start.
- quad_count=0 → done 1 cycle after start, no beats. start pulsed during busy → ignored, beat count unchanged.
- abort after 5 beats with out_ready=1 → out_valid=0 from the next cycle, done pulse with status=10. With OGPU_QUAD_STREAM_CSUM_EN, csum equals the sum of those 5 words only.
